fetch_unit: RTL and testbench

//  Instruction fetch stage of the single-cycle datapath, directly upstream of the extender.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/ack bus plus the control and issue signals
// exchanged with the downstream stage. master = fetch_unit, slave = environment.
interface fetch_unit_if;
   localparam int unsigned XLEN = 32;
   localparam int unsigned JW   = 26;
   localparam int unsigned IMMW = 16;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;
   logic            stall;
   logic            branch_taken;
   logic [XLEN-1:0] branch_offset;
   logic            jump;
   logic [JW-1:0]   jump_target;
   logic [XLEN-1:0] instr;
   logic            instr_valid;
   logic [IMMW-1:0] imm16;
   logic [XLEN-1:0] pc_plus4;
   logic            ext_sel;

   modport master (
      output imem_req, imem_addr, instr, instr_valid, imm16, pc_plus4, ext_sel,
      input  imem_ack, imem_rdata, stall, branch_taken, branch_offset, jump, jump_target
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, imm16, pc_plus4, ext_sel,
      output imem_ack, imem_rdata, stall, branch_taken, branch_offset, jump, jump_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch FSM (IDLE -> FETCH -> ISSUE) and branch/jump redirect.
// Optional macro DECODE_EXT_SEL_EN: decode ext_sel from the opcode (zero-extend for andi/ori/xori).
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clk,
   input logic          reset_n,
   fetch_unit_if.master bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;
   logic            r_instr_valid;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_nxt;
   logic            w_req;
   logic            w_ack_take;
   logic            w_issue_go;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = S_FETCH;
         S_FETCH: if (bus.imem_ack) w_state_nxt = S_ISSUE;
         S_ISSUE: if (!bus.stall)   w_state_nxt = S_FETCH;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State-decoded controls; acks outside FETCH and redirects outside ISSUE never qualify
   always_comb begin
      w_req      = 1'b0;
      w_ack_take = 1'b0;
      w_issue_go = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_req      = 1'b1;
            w_ack_take = bus.imem_ack;
         end
         S_ISSUE: w_issue_go = !bus.stall;
         default: ;
      endcase
   end

   assign w_pc_plus4 = r_pc + XLEN'(4);

   // Redirect priority: jump over branch over sequential
   always_comb begin
      w_pc_nxt = w_pc_plus4;
      if (bus.jump)
         w_pc_nxt = {w_pc_plus4[XLEN-1:XLEN-4], bus.jump_target, 2'b00};
      else if (bus.branch_taken)
         w_pc_nxt = w_pc_plus4 + (bus.branch_offset << 2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_pc <= RESET_PC;
      else if (w_issue_go) r_pc <= w_pc_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
      end else if (w_ack_take) begin
         r_instr       <= bus.imem_rdata;
         r_instr_valid <= 1'b1;
      end else if (w_issue_go) begin
         r_instr_valid <= 1'b0;
      end
   end

`ifdef DECODE_EXT_SEL_EN
   logic [OPW-1:0] w_opcode;
   logic           w_ext_dec;
   logic           r_ext_sel;

   assign w_opcode  = bus.imem_rdata[XLEN-1:XLEN-OPW];
   assign w_ext_dec = !(w_opcode inside {6'h0C, 6'h0D, 6'h0E});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_ext_sel <= 1'b1;
      else if (w_ack_take) r_ext_sel <= w_ext_dec;
   end

   assign bus.ext_sel = r_ext_sel;
`else
   assign bus.ext_sel = 1'b1;
`endif

   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = r_pc;
   assign bus.instr       = r_instr;
   assign bus.instr_valid = r_instr_valid;
   assign bus.imm16       = r_instr[15:0];
   assign bus.pc_plus4    = w_pc_plus4;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed instruction table, mid-fetch reset, and a
// randomized run against a transaction-level reference model.
module tb_fetch_unit;
   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          wait_cyc;
      logic [31:0] rdata;
      int          stall_cyc;
      logic        br;
      logic [31:0] off;
      logic        jmp;
      logic [25:0] jt;
      logic [31:0] next_pc;
      logic        ext_dec;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_ext(input logic dec);
`ifdef DECODE_EXT_SEL_EN
      return dec;
`else
      return (dec === 1'b0) ? 1'b1 : 1'b1;
`endif
   endfunction

   function automatic logic ref_ext(input logic [31:0] word);
`ifdef DECODE_EXT_SEL_EN
      int op;
      op = int'(word >> 26);
      return !(op == 12 || op == 13 || op == 14);
`else
      return (word == 32'h0) ? 1'b1 : 1'b1;
`endif
   endfunction

   function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic br,
                                               input logic [31:0] off, input logic jmp,
                                               input logic [25:0] jt);
      logic [31:0] seq;
      seq = pc + 32'd4;
      if (jmp) return (seq & 32'hF000_0000) | (32'(jt) * 32'd4);
      if (br)  return seq + off * 32'd4;
      return seq;
   endfunction

   // One full instruction: optional wait states, optional stall, then release with redirect
   task automatic do_vec(input vec_t v);
      logic [15:0] imm;
      imm = v.rdata[15:0];
      chk("fetch_req", 32'(bus.imem_req), 32'd1);
      chk("fetch_addr", bus.imem_addr, v.pc);
      chk("fetch_pc_plus4", bus.pc_plus4, v.pc + 32'd4);
      for (int w = 0; w < v.wait_cyc; w++) begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = $urandom;
         step();
         chk("wait_req", 32'(bus.imem_req), 32'd1);
         chk("wait_addr", bus.imem_addr, v.pc);
         chk("wait_valid", 32'(bus.instr_valid), 32'd0);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = v.rdata;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      chk("issue_instr", bus.instr, v.rdata);
      chk("issue_valid", 32'(bus.instr_valid), 32'd1);
      chk("issue_imm16", 32'(bus.imm16), 32'(imm));
      chk("issue_req", 32'(bus.imem_req), 32'd0);
      chk("issue_ext_sel", 32'(bus.ext_sel), 32'(exp_ext(v.ext_dec)));
      for (int s = 0; s < v.stall_cyc; s++) begin
         bus.stall         = 1'b1;
         bus.branch_taken  = 1'b1;
         bus.branch_offset = $urandom;
         bus.jump          = s[0];
         bus.jump_target   = 26'($urandom);
         bus.imem_ack      = 1'b1;
         step();
         chk("stall_addr", bus.imem_addr, v.pc);
         chk("stall_instr", bus.instr, v.rdata);
         chk("stall_valid", 32'(bus.instr_valid), 32'd1);
         chk("stall_req", 32'(bus.imem_req), 32'd0);
      end
      bus.imem_ack      = 1'b0;
      bus.stall         = 1'b0;
      bus.branch_taken  = v.br;
      bus.branch_offset = v.off;
      bus.jump          = v.jmp;
      bus.jump_target   = v.jt;
      step();
      bus.branch_taken = 1'b0;
      bus.jump         = 1'b0;
      chk("next_addr", bus.imem_addr, v.next_pc);
      chk("next_req", 32'(bus.imem_req), 32'd1);
      chk("next_valid", 32'(bus.instr_valid), 32'd0);
   endtask

   initial begin
      typedef enum int {M_IDLE, M_FETCH, M_ISSUE} mphase_t;
      mphase_t     m_phase;
      logic [31:0] m_pc;
      logic [31:0] m_instr;
      logic        m_valid;
      logic        m_ext;
      logic [31:0] w;

      n_checks = 0;
      n_errors = 0;

      vecs[0] = '{32'h0000_0000, 0, 32'h2001_0005, 0, 1'b0, 32'h0000_0000, 1'b0, 26'h0,   32'h0000_0004, 1'b1};
      vecs[1] = '{32'h0000_0004, 3, 32'h3421_FFFF, 0, 1'b0, 32'h0000_0000, 1'b1, 26'h40,  32'h0000_0100, 1'b0};
      vecs[2] = '{32'h0000_0100, 0, 32'h2021_FFFF, 4, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'h0,   32'h0000_0100, 1'b1};
      vecs[3] = '{32'h0000_0100, 1, 32'h3000_1234, 0, 1'b1, 32'h0000_0008, 1'b1, 26'h10,  32'h0000_0040, 1'b0};
      vecs[4] = '{32'h0000_0040, 0, 32'h0C00_0000, 4, 1'b0, 32'h0000_0000, 1'b0, 26'h0,   32'h0000_0044, 1'b1};
      vecs[5] = '{32'h0000_0044, 2, 32'h3800_0001, 0, 1'b1, 32'hFFFF_FFED, 1'b0, 26'h0,   32'hFFFF_FFFC, 1'b0};
      vecs[6] = '{32'hFFFF_FFFC, 0, 32'h1234_5678, 1, 1'b0, 32'h0000_0000, 1'b0, 26'h0,   32'h0000_0000, 1'b1};
      vecs[7] = '{32'h0000_0000, 0, 32'h8C22_0010, 0, 1'b0, 32'h0000_0000, 1'b1, 26'h123, 32'h0000_048C, 1'b1};

      reset_n           = 1'b0;
      bus.imem_ack      = 1'b0;
      bus.imem_rdata    = 32'h0;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_offset = 32'h0;
      bus.jump          = 1'b0;
      bus.jump_target   = 26'h0;

      step();
      step();
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_ext_sel", 32'(bus.ext_sel), 32'd1);

      reset_n = 1'b1;
      chk("idle_req", 32'(bus.imem_req), 32'd0);
      step();

      for (int i = 0; i < 8; i++) do_vec(vecs[i]);

      // Reset in the middle of a pending fetch
      bus.imem_ack = 1'b0;
      step();
      chk("midrst_pre_req", 32'(bus.imem_req), 32'd1);
      chk("midrst_pre_addr", bus.imem_addr, 32'h0000_048C);
      #3;
      reset_n = 1'b0;
      bus.imem_ack = 1'b1;
      #1;
      chk("midrst_req", 32'(bus.imem_req), 32'd0);
      chk("midrst_addr", bus.imem_addr, 32'h0);
      chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
      step();
      bus.imem_ack = 1'b0;
      reset_n = 1'b1;

      m_phase = M_IDLE;
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_valid = 1'b0;
      m_ext   = 1'b1;

      for (int c = 0; c < 800; c++) begin
         chk("rnd_req", 32'(bus.imem_req), 32'(m_phase == M_FETCH));
         chk("rnd_addr", bus.imem_addr, m_pc);
         chk("rnd_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
         chk("rnd_instr", bus.instr, m_instr);
         chk("rnd_imm16", 32'(bus.imm16), m_instr & 32'h0000_FFFF);
         chk("rnd_valid", 32'(bus.instr_valid), 32'(m_valid));
         chk("rnd_ext_sel", 32'(bus.ext_sel), 32'(m_ext));

         w = $urandom;
         if ($urandom_range(0, 3) == 0) w = {6'(32'h0C + $urandom_range(0, 2)), w[25:0]};
         bus.imem_ack      = ($urandom_range(0, 2) != 0);
         bus.imem_rdata    = w;
         bus.stall         = ($urandom_range(0, 2) == 0);
         bus.branch_taken  = ($urandom_range(0, 1) == 1);
         bus.branch_offset = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
         bus.jump          = ($urandom_range(0, 3) == 0);
         bus.jump_target   = 26'($urandom);

         @(posedge clk);
         case (m_phase)
            M_IDLE:  m_phase = M_FETCH;
            M_FETCH: if (bus.imem_ack) begin
               m_instr = bus.imem_rdata;
               m_valid = 1'b1;
               m_ext   = ref_ext(bus.imem_rdata);
               m_phase = M_ISSUE;
            end
            default: if (!bus.stall) begin
               m_pc    = ref_next_pc(m_pc, bus.branch_taken, bus.branch_offset,
                                     bus.jump, bus.jump_target);
               m_valid = 1'b0;
               m_phase = M_FETCH;
            end
         endcase
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
